reg_file_rx: RTL and testbench

- Architectural register file for the out-of-order CPU core.
- Three combinational read ports and one synchronous write port.
- Instantiated inside the register-status block; it supplies operand values while the status block tracks producing functional units.
- All registers are general-purpose; there is no hard-wired zero register.

---
 rtl/reg_file_rx.sv | 89 ++++++++
 tb/tb_reg_file_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reg_file_rx.sv
// Architectural register file: three combinational read ports, one synchronous write port.
// Optional macro REG_FILE_WRITE_BYPASS_EN forwards same-cycle write data onto matching read ports.

module reg_file_rx_rd_port #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_INDEX     = 5,
  parameter int REG_FILE_SIZE = 32
) (
  input  logic [REG_FILE_SIZE-1:0][WORD_SIZE-1:0] regs,
  input  logic [REG_INDEX-1:0]                    get_num,
`ifdef REG_FILE_WRITE_BYPASS_EN
  input  logic                                    wr_en,
  input  logic [REG_INDEX-1:0]                    wr_src,
  input  logic [WORD_SIZE-1:0]                    wr_data,
`endif
  output logic [WORD_SIZE-1:0]                    value
);
`ifdef REG_FILE_WRITE_BYPASS_EN
  // wr_en already excludes reset, so a cleared register is never masked by dropped data
  always_comb begin
    value = regs[get_num];
    if (wr_en && (wr_src == get_num)) value = wr_data;
  end
`else
  always_comb value = regs[get_num];
`endif
endmodule

module reg_file_rx #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_INDEX     = 5,
  parameter int REG_FILE_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_INDEX-1:0] get_num1,
  input  logic [REG_INDEX-1:0] get_num2,
  input  logic [REG_INDEX-1:0] get_num3,
  output logic [WORD_SIZE-1:0] value1,
  output logic [WORD_SIZE-1:0] value2,
  output logic [WORD_SIZE-1:0] value3,
  input  logic [REG_INDEX-1:0] write_reg_src,
  input  logic [WORD_SIZE-1:0] write_reg_data,
  input  logic                 write_reg_enable
);
  localparam int NUM_RD = 3;

  if (REG_FILE_SIZE != (1 << REG_INDEX)) begin : g_size_chk
    $error("reg_file_rx: REG_FILE_SIZE must equal 2**REG_INDEX");
  end

  logic [REG_FILE_SIZE-1:0][WORD_SIZE-1:0] regs;
  logic [NUM_RD-1:0][REG_INDEX-1:0]        rd_addr;
  logic [NUM_RD-1:0][WORD_SIZE-1:0]        rd_data;

  // reset wins over a coincident write
  always_ff @(posedge clk) begin
    if (reset)                 regs <= '0;
    else if (write_reg_enable) regs[write_reg_src] <= write_reg_data;
  end

  assign rd_addr = {get_num3, get_num2, get_num1};

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic byp_en;
  assign byp_en = write_reg_enable && !reset;
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rx_rd_port #(
      .WORD_SIZE     (WORD_SIZE),
      .REG_INDEX     (REG_INDEX),
      .REG_FILE_SIZE (REG_FILE_SIZE)
    ) u_rd (
      .regs    (regs),
      .get_num (rd_addr[p]),
`ifdef REG_FILE_WRITE_BYPASS_EN
      .wr_en   (byp_en),
      .wr_src  (write_reg_src),
      .wr_data (write_reg_data),
`endif
      .value   (rd_data[p])
    );
  end

  assign value1 = rd_data[0];
  assign value2 = rd_data[1];
  assign value3 = rd_data[2];
endmodule

// File: tb/tb_reg_file_rx.sv
// Randomized + directed bench for reg_file_rx against an array-based reference model.
module tb_reg_file_rx;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  get_num1, get_num2, get_num3;
  logic [31:0] value1, value2, value3;
  logic [4:0]  write_reg_src;
  logic [31:0] write_reg_data;
  logic        write_reg_enable;

  int errs   = 0;
  int checks = 0;
  logic [31:0] model [32];

  reg_file_rx #(.WORD_SIZE(32), .REG_INDEX(5), .REG_FILE_SIZE(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .get_num1         (get_num1),
    .get_num2         (get_num2),
    .get_num3         (get_num3),
    .value1           (value1),
    .value2           (value2),
    .value3           (value3),
    .write_reg_src    (write_reg_src),
    .write_reg_data   (write_reg_data),
    .write_reg_enable (write_reg_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // expected read of address a given the currently driven write inputs
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (write_reg_enable && !reset && a == write_reg_src) return write_reg_data;
`endif
    return model[a];
  endfunction

  task automatic step;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (write_reg_enable) begin
      model[write_reg_src] = write_reg_data;
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_reg_enable = 1'b1; write_reg_src = a; write_reg_data = d;
    step;
    write_reg_enable = 1'b0;
  endtask

  task automatic rd3(input string tag, input logic [4:0] a1, a2, a3);
    get_num1 = a1; get_num2 = a2; get_num3 = a3;
    #1;
    chk({tag, "_p1"}, value1, expect_rd(a1));
    chk({tag, "_p2"}, value2, expect_rd(a2));
    chk({tag, "_p3"}, value3, expect_rd(a3));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 'x;
    reset = 1'b1; write_reg_enable = 1'b0; write_reg_src = '0; write_reg_data = '0;
    get_num1 = '0; get_num2 = '0; get_num3 = '0;
    #1;
    step;
    reset = 1'b0;

    // 1: random writes then reset clears everything
    for (int i = 0; i < 8; i++) wr(5'($urandom), $urandom);
    reset = 1'b1; step; reset = 1'b0;
    get_num1 = 5'd0; get_num2 = 5'd7; get_num3 = 5'd31; #1;
    chk("rst_r0", value1, 32'h0);
    chk("rst_r7", value2, 32'h0);
    chk("rst_r31", value3, 32'h0);

    // 2: basic write/read
    wr(5'd5, 32'hDEADBEEF);
    get_num1 = 5'd5; get_num2 = 5'd5; get_num3 = 5'd4; #1;
    chk("wr_p1", value1, 32'hDEADBEEF);
    chk("wr_p2", value2, 32'hDEADBEEF);
    chk("wr_p3", value3, 32'h0);

    // 3: enable gating
    write_reg_enable = 1'b0; write_reg_src = 5'd9; write_reg_data = 32'h12345678;
    step;
    get_num1 = 5'd9; #1;
    chk("gate_off", value1, 32'h0);
    wr(5'd9, 32'h12345678); #1;
    chk("gate_on", value1, 32'h12345678);

    // 4: reset beats a coincident write
    wr(5'd3, 32'h000000A5);
    reset = 1'b1; write_reg_enable = 1'b1; write_reg_src = 5'd3; write_reg_data = 32'hFFFFFFFF;
    step;
    reset = 1'b0; write_reg_enable = 1'b0;
    get_num1 = 5'd3; get_num2 = 5'd9; #1;
    chk("rst_prio_r3", value1, 32'h0);
    chk("rst_prio_r9", value2, 32'h0);

    // 5: full sweep
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int a = 0; a < 32; a++) begin
      get_num1 = 5'(a); get_num2 = 5'(31 - a); get_num3 = 5'((a + 7) % 32); #1;
      chk("sweep_p1", value1, 32'(a) * 32'h01010101);
      chk("sweep_p2", value2, 32'(31 - a) * 32'h01010101);
      chk("sweep_p3", value3, 32'((a + 7) % 32) * 32'h01010101);
    end
    get_num1 = 5'd0; get_num2 = 5'd31; #1;
    chk("sweep_r0", value1, 32'h0);
    chk("sweep_r31", value2, 32'h1F1F1F1F);

    // 6: read during write
    wr(5'd2, 32'h11);
    write_reg_enable = 1'b1; write_reg_src = 5'd2; write_reg_data = 32'h22;
    get_num1 = 5'd2; #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    chk("rdw_pre", value1, 32'h22);
`else
    chk("rdw_pre", value1, 32'h11);
`endif
    step;
    write_reg_enable = 1'b0; #1;
    chk("rdw_post", value1, 32'h22);

    // random traffic, including resets and same-address read/write collisions
    for (int n = 0; n < 400; n++) begin
      reset            = ($urandom_range(0, 24) == 0);
      write_reg_enable = $urandom_range(0, 1);
      write_reg_src    = 5'($urandom);
      write_reg_data   = $urandom;
      rd3("rand",
          ($urandom_range(0, 3) == 0) ? write_reg_src : 5'($urandom),
          5'($urandom),
          ($urandom_range(0, 3) == 0) ? write_reg_src : 5'($urandom));
      step;
    end
    reset = 1'b0; write_reg_enable = 1'b0;
    rd3("final", 5'($urandom), 5'($urandom), 5'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
